// File: rtl/wb_stage_if.sv
// rtl/wb_stage_if.sv - MEM/WB pipeline inputs and register-file write port of the write-back stage
// Bypass read signals exist only when WB_BYPASS_EN is defined.
interface wb_stage_if #(
    parameter int XLEN = 32
) ();
    logic            M_Valid;
    logic            M_RegWrite;
    logic [1:0]      M_ResultSrc;
    logic [4:0]      M_Rd;
    logic [2:0]      M_Funct3;
    logic [XLEN-1:0] M_ALUResult;
    logic [XLEN-1:0] M_ReadData;
    logic [XLEN-1:0] M_PCPlus4;
    logic            WE;
    logic [4:0]      A3;
    logic [XLEN-1:0] WD;
`ifdef WB_BYPASS_EN
    logic [4:0]      RA1;
    logic [4:0]      RA2;
    logic [XLEN-1:0] RF_RD1;
    logic [XLEN-1:0] RF_RD2;
    logic [XLEN-1:0] RD1_Fwd;
    logic [XLEN-1:0] RD2_Fwd;
`endif

    modport master (
        output M_Valid, M_RegWrite, M_ResultSrc, M_Rd, M_Funct3,
               M_ALUResult, M_ReadData, M_PCPlus4,
`ifdef WB_BYPASS_EN
        output RA1, RA2, RF_RD1, RF_RD2,
        input  RD1_Fwd, RD2_Fwd,
`endif
        input  WE, A3, WD
    );

    modport slave (
        input  M_Valid, M_RegWrite, M_ResultSrc, M_Rd, M_Funct3,
               M_ALUResult, M_ReadData, M_PCPlus4,
`ifdef WB_BYPASS_EN
        input  RA1, RA2, RF_RD1, RF_RD2,
        output RD1_Fwd, RD2_Fwd,
`endif
        output WE, A3, WD
    );
endinterface

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V write-back stage: WB register, load alignment, x0 suppression, retire counter
// Define WB_BYPASS_EN to forward the in-flight write to decode reads.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Flush,
    wb_stage_if.slave        wb,
    output logic [CNT_W-1:0] InstRet
);
    logic            valid;
    logic            regwrite;
    logic [1:0]      resultsrc;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [XLEN-1:0] aluresult;
    logic [XLEN-1:0] readdata;
    logic [XLEN-1:0] pcplus4;

    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] result;
    logic            we;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            valid     <= 1'b0;
            regwrite  <= 1'b0;
            resultsrc <= 2'b00;
            rd        <= 5'd0;
            funct3    <= 3'b000;
            aluresult <= '0;
            readdata  <= '0;
            pcplus4   <= '0;
            InstRet   <= '0;
        end else begin
            // An instruction retires on the edge that moves it out of WB.
            if (valid && !Stall && !Flush)
                InstRet <= InstRet + CNT_W'(1);
            if (Flush) begin
                valid    <= 1'b0;
                regwrite <= 1'b0;
            end else if (!Stall) begin
                valid     <= wb.M_Valid;
                regwrite  <= wb.M_RegWrite;
                resultsrc <= wb.M_ResultSrc;
                rd        <= wb.M_Rd;
                funct3    <= wb.M_Funct3;
                aluresult <= wb.M_ALUResult;
                readdata  <= wb.M_ReadData;
                pcplus4   <= wb.M_PCPlus4;
            end
        end
    end

    always_comb begin
        byte_sel = readdata[7:0];
        case (aluresult[1:0])
            2'd0:    byte_sel = readdata[7:0];
            2'd1:    byte_sel = readdata[15:8];
            2'd2:    byte_sel = readdata[23:16];
            default: byte_sel = readdata[31:24];
        endcase
        // Halfword/word loads ignore aluresult[0]; misalignment never traps.
        half_sel = aluresult[1] ? readdata[31:16] : readdata[15:0];

        load_val = readdata;
        case (funct3)
            3'b000:  load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sel};
            3'b001:  load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sel};
            default: load_val = readdata;
        endcase

        result = aluresult;
        case (resultsrc)
            2'b01:   result = load_val;
            2'b10:   result = pcplus4;
            default: result = aluresult;
        endcase
    end

    assign we    = valid & regwrite & (rd != 5'd0);
    assign wb.WE = we;
    assign wb.A3 = rd;
    assign wb.WD = result;

`ifdef WB_BYPASS_EN
    // rd = 0 already forces we low, so x0 reads never pick up forwarded data.
    assign wb.RD1_Fwd = (we && (wb.RA1 == rd)) ? result : wb.RF_RD1;
    assign wb.RD2_Fwd = (we && (wb.RA2 == rd)) ? result : wb.RF_RD2;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage
module tb_wb_stage;
    logic        CLK;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic [63:0] InstRet;
    int          n_cmp;
    int          n_err;

    wb_stage_if #(.XLEN(32)) wb ();

    wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .Stall   (Stall),
        .Flush   (Flush),
        .wb      (wb.slave),
        .InstRet (InstRet)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                         input logic [4:0] rd, input logic [2:0] f3,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [31:0] pc4);
        wb.M_Valid     = v;
        wb.M_RegWrite  = rw;
        wb.M_ResultSrc = src;
        wb.M_Rd        = rd;
        wb.M_Funct3    = f3;
        wb.M_ALUResult = alu;
        wb.M_ReadData  = rdata;
        wb.M_PCPlus4   = pc4;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] a3,
                             input logic [31:0] wd, input logic [63:0] ret);
        check({tag, ".WE"}, 64'(wb.WE), 64'(we));
        check({tag, ".A3"}, 64'(wb.A3), 64'(a3));
        check({tag, ".WD"}, 64'(wb.WD), 64'(wd));
        check({tag, ".InstRet"}, InstRet, ret);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b1;
        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd1, 3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef WB_BYPASS_EN
        wb.RA1 = 5'd0; wb.RA2 = 5'd0; wb.RF_RD1 = 32'h0; wb.RF_RD2 = 32'h0;
`endif
        tick();
        tick();
        check_out("reset", 1'b0, 5'd0, 32'h0, 64'd0);

        Reset = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd5, 3'b000, 32'h0000_1234, 32'h0, 32'h0);
        tick();
        check_out("alu", 1'b1, 5'd5, 32'h0000_1234, 64'd0);

        drive(1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        check("alu_retired", InstRet, 64'd1);
        check("bubble.WE", 64'(wb.WE), 64'd0);

        drive(1'b1, 1'b1, 2'b01, 5'd10, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        tick();
        check_out("lb", 1'b1, 5'd10, 32'hFFFF_FF80, 64'd1);

        drive(1'b1, 1'b1, 2'b01, 5'd11, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        tick();
        check_out("lbu", 1'b1, 5'd11, 32'h0000_0080, 64'd2);

        drive(1'b1, 1'b1, 2'b01, 5'd12, 3'b001, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        tick();
        check_out("lh", 1'b1, 5'd12, 32'hFFFF_80FF, 64'd3);

        drive(1'b1, 1'b1, 2'b01, 5'd13, 3'b101, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        tick();
        check_out("lhu", 1'b1, 5'd13, 32'h0000_80FF, 64'd4);

        drive(1'b1, 1'b1, 2'b01, 5'd14, 3'b010, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        tick();
        check_out("lw", 1'b1, 5'd14, 32'h80FF_7F01, 64'd5);

        drive(1'b1, 1'b1, 2'b01, 5'd15, 3'b000, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        tick();
        check_out("lb_off1", 1'b1, 5'd15, 32'h0000_007F, 64'd6);

        drive(1'b1, 1'b1, 2'b10, 5'd0, 3'b000, 32'h0000_0040, 32'h0, 32'h0000_0104);
        tick();
        check_out("jal_x0", 1'b0, 5'd0, 32'h0000_0104, 64'd7);

        drive(1'b1, 1'b1, 2'b11, 5'd9, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0000_0200);
        tick();
        check_out("alu_src11", 1'b1, 5'd9, 32'hCAFE_0001, 64'd8);

        Stall = 1'b1;
        drive(1'b1, 1'b1, 2'b00, 5'd3, 3'b000, 32'h0000_5555, 32'h0, 32'h0);
        tick();
        check_out("stall1", 1'b1, 5'd9, 32'hCAFE_0001, 64'd8);
        tick();
        check_out("stall2", 1'b1, 5'd9, 32'hCAFE_0001, 64'd8);
        tick();
        check_out("stall3", 1'b1, 5'd9, 32'hCAFE_0001, 64'd8);

        Stall = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 5'd0, 3'b000, 32'h0, 32'h0, 32'h0);
        tick();
        check_out("unstall", 1'b0, 5'd0, 32'h0, 64'd9);
        tick();
        check("unstall_once", InstRet, 64'd9);

        drive(1'b1, 1'b1, 2'b00, 5'd4, 3'b000, 32'h0000_0044, 32'h0, 32'h0);
        tick();
        check_out("pre_flush", 1'b1, 5'd4, 32'h0000_0044, 64'd9);

        Stall = 1'b1;
        Flush = 1'b1;
        tick();
        check("flush.WE", 64'(wb.WE), 64'd0);
        check("flush.InstRet", InstRet, 64'd9);

        Stall = 1'b0;
        Flush = 1'b0;
        drive(1'b1, 1'b1, 2'b00, 5'd6, 3'b000, 32'h0000_0066, 32'h0, 32'h0);
        tick();
        check_out("post_flush", 1'b1, 5'd6, 32'h0000_0066, 64'd9);

        Stall = 1'b1;
        tick();
        check_out("stall_before_reset", 1'b1, 5'd6, 32'h0000_0066, 64'd9);
        Reset = 1'b1;
        tick();
        check_out("reset_in_stall", 1'b0, 5'd0, 32'h0, 64'd0);
        Reset = 1'b0;
        Stall = 1'b0;

`ifdef WB_BYPASS_EN
        drive(1'b1, 1'b1, 2'b00, 5'd7, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
        wb.RA1 = 5'd7; wb.RA2 = 5'd8; wb.RF_RD1 = 32'h1; wb.RF_RD2 = 32'h2;
        tick();
        check("byp.RD1", 64'(wb.RD1_Fwd), 64'hDEAD_BEEF);
        check("byp.RD2", 64'(wb.RD2_Fwd), 64'h2);

        drive(1'b1, 1'b1, 2'b00, 5'd0, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0);
        wb.RA1 = 5'd0;
        tick();
        check("byp_x0.WE", 64'(wb.WE), 64'd0);
        check("byp_x0.RD1", 64'(wb.RD1_Fwd), 64'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
